// File: rtl/eth_frame_arbiter_if.sv
// AXI4-Stream bundle used on every arbiter port (tdata/tkeep/tvalid/tready/tlast).
// The master modport drives the beat; the slave modport drives tready.
interface eth_frame_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = DATA_W / 8
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/eth_frame_arbiter.sv
// Eight-input strict-priority AXI4-Stream frame arbiter (index 7 highest), never interleaving frames.
// Define ETH_FRAME_ARBITER_OUTPUT_REG_EN to register m_axis through a two-entry skid buffer.
module eth_frame_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8
) (
  input logic                 clk,
  input logic                 rst,
  eth_frame_arbiter_if.slave  s_axis_7,
  eth_frame_arbiter_if.slave  s_axis_6,
  eth_frame_arbiter_if.slave  s_axis_5,
  eth_frame_arbiter_if.slave  s_axis_4,
  eth_frame_arbiter_if.slave  s_axis_3,
  eth_frame_arbiter_if.slave  s_axis_2,
  eth_frame_arbiter_if.slave  s_axis_1,
  eth_frame_arbiter_if.slave  s_axis_0,
  eth_frame_arbiter_if.master m_axis
);

  // A beat is carried as {tlast, tkeep, tdata}.
  localparam int BEAT_W = C_AXIS_TDATA_WIDTH + C_AXIS_TKEEP_WIDTH + 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  logic [BEAT_W-1:0] s_beat [8];
  logic [7:0]        s_valid;
  logic [7:0]        s_ready;

  assign s_beat[7]  = {s_axis_7.tlast, s_axis_7.tkeep, s_axis_7.tdata};
  assign s_beat[6]  = {s_axis_6.tlast, s_axis_6.tkeep, s_axis_6.tdata};
  assign s_beat[5]  = {s_axis_5.tlast, s_axis_5.tkeep, s_axis_5.tdata};
  assign s_beat[4]  = {s_axis_4.tlast, s_axis_4.tkeep, s_axis_4.tdata};
  assign s_beat[3]  = {s_axis_3.tlast, s_axis_3.tkeep, s_axis_3.tdata};
  assign s_beat[2]  = {s_axis_2.tlast, s_axis_2.tkeep, s_axis_2.tdata};
  assign s_beat[1]  = {s_axis_1.tlast, s_axis_1.tkeep, s_axis_1.tdata};
  assign s_beat[0]  = {s_axis_0.tlast, s_axis_0.tkeep, s_axis_0.tdata};
  assign s_valid    = {s_axis_7.tvalid, s_axis_6.tvalid, s_axis_5.tvalid, s_axis_4.tvalid,
                       s_axis_3.tvalid, s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
  assign s_axis_7.tready = s_ready[7];
  assign s_axis_6.tready = s_ready[6];
  assign s_axis_5.tready = s_ready[5];
  assign s_axis_4.tready = s_ready[4];
  assign s_axis_3.tready = s_ready[3];
  assign s_axis_2.tready = s_ready[2];
  assign s_axis_1.tready = s_ready[1];
  assign s_axis_0.tready = s_ready[0];

  state_e            state_q;
  state_e            state_d;
  logic [2:0]        sel_q;
  logic [2:0]        sel_d;
  logic [2:0]        cand_s;
  logic              any_valid_s;
  logic [2:0]        grant_s;
  logic              grant_act_s;
  logic              fwd_valid_s;
  logic [BEAT_W-1:0] fwd_beat_s;
  logic              fwd_last_s;
  logic              sink_ready_s;
  logic              in_hs_s;

  // Highest-index valid input; the ascending scan lets later (higher) indices overwrite.
  always_comb begin
    cand_s      = 3'd0;
    any_valid_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand_s      = s_valid[i] ? 3'(i) : cand_s;
      any_valid_s = any_valid_s | s_valid[i];
    end
  end

  // Route the granted input to the sink; reset forces every ready and the output valid low.
  always_comb begin
    grant_s     = 3'd0;
    grant_act_s = 1'b0;
    s_ready     = 8'd0;
    if (state_q == ST_LOCKED) begin
      grant_s     = sel_q;
      grant_act_s = 1'b1;
    end else begin
      grant_s     = cand_s;
      grant_act_s = any_valid_s;
    end
    fwd_valid_s = grant_act_s & s_valid[grant_s] & ~rst;
    fwd_beat_s  = fwd_valid_s ? s_beat[grant_s] : {BEAT_W{1'b0}};
    fwd_last_s  = fwd_beat_s[BEAT_W-1];
    if (grant_act_s && !rst) begin
      s_ready[grant_s] = sink_ready_s;
    end else begin
      s_ready = 8'd0;
    end
    in_hs_s = fwd_valid_s & sink_ready_s;
  end

  // Lock onto a multi-beat frame at its first handshake; release on its tlast handshake.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_s && !fwd_last_s) begin
          state_d = ST_LOCKED;
          sel_d   = cand_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (in_hs_s && fwd_last_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

`ifdef ETH_FRAME_ARBITER_OUTPUT_REG_EN
  logic [BEAT_W-1:0] buf0_q;
  logic [BEAT_W-1:0] buf0_d;
  logic [BEAT_W-1:0] buf1_q;
  logic [BEAT_W-1:0] buf1_d;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              pop_s;

  // Two entries let the input side keep accepting while the head waits on m_axis_tready.
  assign sink_ready_s = (cnt_q != 2'd2);
  assign pop_s        = (cnt_q != 2'd0) & m_axis.tready;

  // Skid buffer: buf0 is always the head; vacated slots are zeroed so idle outputs read 0.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case ({in_hs_s, pop_s})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          buf0_d = fwd_beat_s;
        end else begin
          buf1_d = fwd_beat_s;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        buf1_d = {BEAT_W{1'b0}};
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          buf0_d = fwd_beat_s;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fwd_beat_s;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Skid buffer storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0_q <= {BEAT_W{1'b0}};
      buf1_q <= {BEAT_W{1'b0}};
      cnt_q  <= 2'd0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign m_axis.tvalid = (cnt_q != 2'd0);
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = buf0_q;
`else
  assign sink_ready_s  = m_axis.tready;
  assign m_axis.tvalid = fwd_valid_s;
  assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = fwd_beat_s;
`endif

endmodule

// File: tb/tb_eth_frame_arbiter.sv
// Randomized bench for eth_frame_arbiter: sources replay queued frames, a frame-level
// reference model predicts the grant each cycle and reassembles frames for comparison.
module tb_eth_frame_arbiter;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data [8];
  logic [7:0] s_valid;
  logic [7:0] s_last;
  logic [7:0] rdy_vec;
  logic       m_tready;

  always #5 clk = ~clk;

  eth_frame_arbiter_if #(.DATA_W(DW)) s_if [8] ();
  eth_frame_arbiter_if #(.DATA_W(DW)) m_if ();

  for (genvar g = 0; g < 8; g++) begin : g_src
    assign s_if[g].tdata  = s_data[g];
    assign s_if[g].tkeep  = 1'b1;
    assign s_if[g].tvalid = s_valid[g];
    assign s_if[g].tlast  = s_last[g];
    assign rdy_vec[g]     = s_if[g].tready;
  end
  assign m_if.tready = m_tready;

  eth_frame_arbiter #(.C_AXIS_TDATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_7(s_if[7]), .s_axis_6(s_if[6]), .s_axis_5(s_if[5]), .s_axis_4(s_if[4]),
    .s_axis_3(s_if[3]), .s_axis_2(s_if[2]), .s_axis_1(s_if[1]), .s_axis_0(s_if[0]),
    .m_axis(m_if)
  );

  logic [8:0] beat_q [8][$];
  int         fr_len_q [8][$];
  logic [7:0] fr_seed_q [8][$];
  logic [7:0] cur_bytes [$];
  int         order_q [$];
  logic [7:0] en;
  logic [7:0] hs_vec;
  int         vprob, rprob;
  bit         in_frame;
  int         owner;
  int         frames_out;
  int         total, bad;

  function automatic logic [7:0] byte_of(int i, logic [7:0] seed, int k);
    return (seed + 8'(k * 7)) ^ 8'(i * 29);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(int i, int len);
    logic [7:0] seed;
    seed = 8'($urandom);
    fr_len_q[i].push_back(len);
    fr_seed_q[i].push_back(seed);
    for (int k = 0; k < len; k++) beat_q[i].push_back({1'(k == len - 1), byte_of(i, seed, k)});
  endtask

  function automatic bit busy();
    bit b;
    b = in_frame;
    for (int i = 0; i < 8; i++) if (beat_q[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  // One clock: update sources at negedge, then predict and check the settled outputs.
  task automatic step();
    int         win;
    logic       exp_v;
    logic [7:0] exp_rdy;
    int         len, errs;
    logic [7:0] seed;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (!(s_valid[i] && !hs_vec[i])) begin
        if (en[i] && beat_q[i].size() != 0 && $urandom_range(99) < vprob) begin
          s_valid[i] = 1'b1;
          s_data[i]  = beat_q[i][0][7:0];
          s_last[i]  = beat_q[i][0][8];
        end else begin
          s_valid[i] = 1'b0;
          s_data[i]  = 8'd0;
          s_last[i]  = 1'b0;
        end
      end
    end
    hs_vec   = 8'd0;
    m_tready = ($urandom_range(99) < rprob);
    #1;
    win = -1;
    if (in_frame) win = owner;
    else for (int i = 0; i < 8; i++) if (s_valid[i]) win = i;
    exp_v   = 1'b0;
    exp_rdy = 8'd0;
    if (win >= 0) begin
      exp_v        = s_valid[win];
      exp_rdy[win] = m_tready;
    end
    chk("m_tvalid", m_if.tvalid, exp_v);
    chk("s_tready", rdy_vec, exp_rdy);
    if (exp_v) begin
      chk("m_tdata", m_if.tdata, s_data[win]);
      chk("m_tlast", m_if.tlast, s_last[win]);
      if (m_tready) begin
        hs_vec[win] = 1'b1;
        void'(beat_q[win].pop_front());
        if (!in_frame) begin
          in_frame = 1'b1;
          owner    = win;
          cur_bytes.delete();
        end
        cur_bytes.push_back(m_if.tdata);
        if (m_if.tlast) begin
          len  = fr_len_q[win].pop_front();
          seed = fr_seed_q[win].pop_front();
          errs = 0;
          for (int k = 0; k < cur_bytes.size(); k++)
            if (cur_bytes[k] !== byte_of(win, seed, k)) errs++;
          chk("frame_len", cur_bytes.size(), len);
          chk("frame_bytes", errs, 0);
          order_q.push_back(win);
          frames_out++;
          in_frame = 1'b0;
        end
      end
    end
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain", busy(), 0);
  endtask

  initial begin
    int base;
    total = 0; bad = 0; frames_out = 0; in_frame = 1'b0; owner = 0;
    en = 8'd0; hs_vec = 8'd0; vprob = 100; rprob = 100;
    s_valid = 8'd0; s_last = 8'd0; m_tready = 1'b1;
    for (int i = 0; i < 8; i++) s_data[i] = 8'd0;

    // Reset holds everything low even with a valid source present.
    s_valid[3] = 1'b1;
    s_data[3]  = 8'hA5;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tvalid", m_if.tvalid, 1'b0);
    chk("rst_tready", rdy_vec, 8'd0);
    @(negedge clk);
    s_valid[3] = 1'b0;
    s_data[3]  = 8'd0;
    rst = 1'b0;

    // 64-byte frame on input 0.
    add_frame(0, 64);
    en = 8'h01;
    drain(300);
    chk("t1_frames", frames_out, 1);
    chk("t1_src", order_q[0], 0);

    // Inputs 0 and 7 start together: 7 wins.
    add_frame(0, 10);
    add_frame(7, 12);
    en = 8'h81;
    drain(300);
    chk("t2_first", order_q[1], 7);
    chk("t2_second", order_q[2], 0);

    // Input 6 arrives while input 2 is mid-frame: no preemption.
    add_frame(2, 20);
    en = 8'h04;
    repeat (5) step();
    add_frame(6, 8);
    en = 8'h44;
    drain(300);
    chk("t3_first", order_q[3], 2);
    chk("t3_second", order_q[4], 6);

    // 1600-byte frame with random output backpressure.
    rprob = 50;
    en = 8'h08;
    add_frame(3, 1600);
    drain(8000);
    chk("t4_frames", frames_out, 6);

    // All inputs, staggered and repeated, with random gaps and backpressure.
    rprob = 70;
    vprob = 70;
    en = 8'hFF;
    base = frames_out;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 8; i++) begin
        add_frame(i, $urandom_range(1, 40));
        repeat (30) step();
      end
    end
    drain(6000);
    chk("t5_frames", frames_out - base, 24);

    // Reset for 3 cycles in the middle of an input-4 frame.
    vprob = 100;
    rprob = 100;
    en = 8'h10;
    add_frame(4, 30);
    repeat (10) step();
    repeat (3) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_tvalid", m_if.tvalid, 1'b0);
      chk("mid_rst_tready", rdy_vec, 8'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      beat_q[i].delete();
      fr_len_q[i].delete();
      fr_seed_q[i].delete();
      s_data[i] = 8'd0;
    end
    s_valid = 8'd0;
    s_last = 8'd0;
    hs_vec = 8'd0;
    in_frame = 1'b0;
    rst = 1'b0;
    base = order_q.size();
    add_frame(1, 5);
    add_frame(5, 6);
    en = 8'h22;
    drain(300);
    chk("t6_first", order_q[base], 5);
    chk("t6_second", order_q[base + 1], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
